// File: rtl/fwd_hazard_unit_if.sv
// Signal bundle between the pipeline and fwd_hazard_unit: ID-stage fields in,
// EX operand selects, stall/bubble/freeze controls and shadow snapshot out.
interface fwd_hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       id_dst;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic             dmem_busy;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
    logic             bubble;
    logic             freeze;
    logic [CNT_W-1:0] stall_cnt;
    // Shadow snapshot: {EX v,dst,rw,mr,rs,rt,use_rt | MEM v,dst,rw,mr | WB v,dst,rw,mr}
    logic [34:0]      shadow;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread,
        output flush, dmem_busy,
        input  fwd_a, fwd_b, stall, bubble, freeze, stall_cnt, shadow
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread,
        input  flush, dmem_busy,
        output fwd_a, fwd_b, stall, bubble, freeze, stall_cnt, shadow
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use/flush/freeze hazard controller for the 5-stage pipeline.
// Forward selects and shadow state are registered; stall, bubble and freeze are combinational.
module fwd_hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    fwd_hazard_unit_if.slave bus
);
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
    } ex_entry_t;

    typedef struct packed {
        logic       v;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } stage_entry_t;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_FLUSH = 2'd1,
        ACT_STALL = 2'd2,
        ACT_LOAD  = 2'd3
    } act_e;

    localparam ex_entry_t        EX_EMPTY  = ex_entry_t'(19'd0);
    localparam stage_entry_t     STG_EMPTY = stage_entry_t'(8'd0);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_entry_t        r_ex;
    stage_entry_t     r_mem;
    stage_entry_t     r_wb;
    logic [1:0]       r_fwd_a;
    logic [1:0]       r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_ex_live;
    logic       w_mem_live;
    logic       w_lu;
    logic       w_stall;
    logic       w_bubble;
    act_e       w_act;
    ex_entry_t  w_ex_nxt;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    // The instruction in EX lands in MEM next, so it is the newest producer and wins.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       ex_live,
        input logic [4:0] ex_dst,
        input logic       mem_live,
        input logic [4:0] mem_dst
    );
        logic [1:0] sel;
        if (ex_live && (ex_dst == src)) begin
            sel = SEL_EX;
        end else if (mem_live && (mem_dst == src)) begin
            sel = SEL_MEM;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    assign w_ex_live  = r_ex.v & r_ex.rw & (r_ex.dst != 5'd0);
    assign w_mem_live = r_mem.v & r_mem.rw & (r_mem.dst != 5'd0);
    assign w_lu       = bus.id_valid & r_ex.v & r_ex.mr & (r_ex.dst != 5'd0) &
                        ((r_ex.dst == bus.id_rs) | (bus.id_uses_rt & (r_ex.dst == bus.id_rt)));

    // Cycle action in priority order: freeze, flush, load-use stall, normal advance.
    always_comb begin
        w_act    = ACT_LOAD;
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        if (bus.dmem_busy) begin
            w_act = ACT_HOLD;
        end else if (bus.flush) begin
            w_act    = ACT_FLUSH;
            w_bubble = 1'b1;
        end else if (w_lu) begin
            w_act    = ACT_STALL;
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end else begin
            w_act = ACT_LOAD;
        end
    end

    // Next EX entry and operand selects for the instruction about to enter EX.
    always_comb begin
        w_ex_nxt    = EX_EMPTY;
        w_fwd_a_nxt = SEL_RF;
        w_fwd_b_nxt = SEL_RF;
        case (w_act)
            ACT_LOAD: begin
                w_ex_nxt.v      = bus.id_valid;
                w_ex_nxt.dst    = bus.id_dst;
                w_ex_nxt.rw     = bus.id_regwrite;
                w_ex_nxt.mr     = bus.id_memread;
                w_ex_nxt.rs     = bus.id_rs;
                w_ex_nxt.rt     = bus.id_rt;
                w_ex_nxt.use_rt = bus.id_uses_rt;
                w_fwd_a_nxt     = fwd_select(bus.id_rs, w_ex_live, r_ex.dst, w_mem_live, r_mem.dst);
                if (bus.id_uses_rt) begin
                    w_fwd_b_nxt = fwd_select(bus.id_rt, w_ex_live, r_ex.dst, w_mem_live, r_mem.dst);
                end else begin
                    w_fwd_b_nxt = SEL_RF;
                end
            end
            ACT_FLUSH, ACT_STALL: begin
                w_ex_nxt    = EX_EMPTY;
                w_fwd_a_nxt = SEL_RF;
                w_fwd_b_nxt = SEL_RF;
            end
            ACT_HOLD: begin
                w_ex_nxt    = r_ex;
                w_fwd_a_nxt = r_fwd_a;
                w_fwd_b_nxt = r_fwd_b;
            end
            default: begin
                w_ex_nxt    = EX_EMPTY;
                w_fwd_a_nxt = SEL_RF;
                w_fwd_b_nxt = SEL_RF;
            end
        endcase
    end

    // Shadow pipeline, forward selects and stall counter; a freeze holds all of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex        <= EX_EMPTY;
            r_mem       <= STG_EMPTY;
            r_wb        <= STG_EMPTY;
            r_fwd_a     <= SEL_RF;
            r_fwd_b     <= SEL_RF;
            r_stall_cnt <= CNT_ZERO;
        end else if (w_act != ACT_HOLD) begin
            r_ex    <= w_ex_nxt;
            r_mem   <= {r_ex.v, r_ex.dst, r_ex.rw, r_ex.mr};
            r_wb    <= r_mem;
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
            if ((w_act == ACT_STALL) && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end else begin
            r_ex        <= r_ex;
            r_mem       <= r_mem;
            r_wb        <= r_wb;
            r_fwd_a     <= r_fwd_a;
            r_fwd_b     <= r_fwd_b;
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.stall     = w_stall;
    assign bus.bubble    = w_bubble;
    assign bus.freeze    = bus.dmem_busy;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.shadow    = {r_ex, r_mem, r_wb};
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized + directed bench for fwd_hazard_unit: a pipeline reference model pushes expected
// responses into a scoreboard queue, and a separate monitor compares them against the DUT.
module tb_fwd_hazard_unit;
    localparam int CNT_W = 2;

    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
        int rs;
        int rt;
        bit use_rt;
    } instr_t;

    typedef struct {
        bit          stall;
        bit          bubble;
        bit          freeze;
        int          fwd_a;
        int          fwd_b;
        int          cnt;
        logic [34:0] shadow;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.CNT_W(CNT_W)) bus();
    fwd_hazard_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    exp_t   sbq[$];
    instr_t pipe[3];    // reference pipeline: 0 = EX, 1 = MEM, 2 = WB
    int     m_fwd_a  = 0;
    int     m_fwd_b  = 0;
    int     m_cnt    = 0;

    function automatic instr_t mk(bit v, int rs, int rt, bit use_rt, int dst, bit rw, bit mr);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.use_rt = use_rt; i.dst = dst; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t empty_instr();
        return mk(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endfunction

    function automatic bit produces(instr_t e, int r);
        return e.v && e.rw && (e.dst != 0) && (e.dst == r);
    endfunction

    // Youngest in-flight producer of r: EX result -> 2, MEM result -> 1, none -> 0.
    function automatic int fwd_for(int r);
        for (int age = 0; age < 2; age++) begin
            if (produces(pipe[age], r)) return 2 - age;
        end
        return 0;
    endfunction

    function automatic logic [34:0] pack_shadow();
        return {pipe[0].v, 5'(pipe[0].dst), pipe[0].rw, pipe[0].mr, 5'(pipe[0].rs), 5'(pipe[0].rt),
                pipe[0].use_rt,
                pipe[1].v, 5'(pipe[1].dst), pipe[1].rw, pipe[1].mr,
                pipe[2].v, 5'(pipe[2].dst), pipe[2].rw, pipe[2].mr};
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i.v      = ($urandom_range(0, 9) != 0);
        i.rs     = $urandom_range(0, 7);
        i.rt     = $urandom_range(0, 7);
        i.use_rt = ($urandom_range(0, 9) < 6);
        i.dst    = $urandom_range(0, 7);
        i.mr     = ($urandom_range(0, 9) < 3);
        i.rw     = i.mr || ($urandom_range(0, 9) < 6);
        return i;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    // Drive one cycle of ID inputs, step the reference model and queue what the DUT must show.
    task automatic issue(input instr_t id, input bit fl, input bit busy, input bit do_rst,
                         output bit stalled);
        exp_t   e;
        instr_t nxt;
        bit     lu;
        bus.id_valid    = id.v;
        bus.id_rs       = 5'(id.rs);
        bus.id_rt       = 5'(id.rt);
        bus.id_uses_rt  = id.use_rt;
        bus.id_dst      = 5'(id.dst);
        bus.id_regwrite = id.rw;
        bus.id_memread  = id.mr;
        bus.flush       = fl;
        bus.dmem_busy   = busy;
        rst             = do_rst;

        lu = id.v && pipe[0].v && pipe[0].mr && (pipe[0].dst != 0) &&
             ((pipe[0].dst == id.rs) || (id.use_rt && (pipe[0].dst == id.rt)));
        e.freeze = busy;
        e.stall  = !busy && !fl && lu;
        e.bubble = !busy && (fl || lu);

        if (do_rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = empty_instr();
            m_fwd_a = 0;
            m_fwd_b = 0;
            m_cnt   = 0;
        end else if (!busy) begin
            if (e.bubble) begin
                nxt     = empty_instr();
                m_fwd_a = 0;
                m_fwd_b = 0;
            end else begin
                nxt     = id;
                m_fwd_a = fwd_for(id.rs);
                m_fwd_b = id.use_rt ? fwd_for(id.rt) : 0;
            end
            if (e.stall && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
        e.fwd_a  = m_fwd_a;
        e.fwd_b  = m_fwd_b;
        e.cnt    = m_cnt;
        e.shadow = pack_shadow();
        sbq.push_back(e);
        stalled = e.stall;
        @(negedge clk);
        cyc++;
    endtask

    // Present an instruction, holding it in ID for as long as a load-use stall lasts.
    task automatic send(input instr_t id);
        bit st = 1'b1;
        int n  = 0;
        while (st && (n < 4)) begin
            issue(id, 1'b0, 1'b0, 1'b0, st);
            n++;
        end
        chk("stall_bound", 64'(st), 64'd0);
    endtask

    // Monitor: combinational controls just before the edge, registered state just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sbq.size() > 0) begin
                e = sbq[0];
                chk("stall",  64'(bus.stall),  64'(e.stall));
                chk("bubble", 64'(bus.bubble), 64'(e.bubble));
                chk("freeze", 64'(bus.freeze), 64'(e.freeze));
                @(posedge clk);
                #1;
                chk("fwd_a",     64'(bus.fwd_a),     64'(e.fwd_a));
                chk("fwd_b",     64'(bus.fwd_b),     64'(e.fwd_b));
                chk("stall_cnt", 64'(bus.stall_cnt), 64'(e.cnt));
                chk("shadow",    64'(bus.shadow),    64'(e.shadow));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        instr_t cur;
        bit     st;
        bit     fl;
        bit     bz;
        bit     rr;
        int     wait_n;
        for (int k = 0; k < 3; k++) pipe[k] = empty_instr();
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_dst = 5'd0; bus.id_regwrite = 1'b0; bus.id_memread = 1'b0;
        bus.flush = 1'b0; bus.dmem_busy = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state with an empty ID stage
        send(empty_instr());
        // add $3,$1,$2 ; sub $5,$3,$4
        send(mk(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0));
        send(mk(1'b1, 3, 4, 1'b1, 5, 1'b1, 1'b0));
        // distance 2, then newer-wins
        send(mk(1'b1, 1, 2, 1'b1, 7, 1'b1, 1'b0));
        send(mk(1'b1, 1, 2, 1'b1, 6, 1'b1, 1'b0));
        send(mk(1'b1, 7, 0, 1'b0, 9, 1'b1, 1'b0));
        send(mk(1'b1, 1, 2, 1'b1, 7, 1'b1, 1'b0));
        send(mk(1'b1, 2, 3, 1'b1, 7, 1'b1, 1'b0));
        send(mk(1'b1, 7, 7, 1'b1, 9, 1'b1, 1'b0));
        // lw $8 ; add $9,$8,$8
        send(mk(1'b1, 1, 0, 1'b0, 8, 1'b1, 1'b1));
        send(mk(1'b1, 8, 8, 1'b1, 9, 1'b1, 1'b0));
        send(empty_instr());
        // register zero: writer then reader, load then user
        send(mk(1'b1, 1, 2, 1'b1, 0, 1'b1, 1'b0));
        send(mk(1'b1, 0, 0, 1'b1, 4, 1'b1, 1'b0));
        send(mk(1'b1, 1, 0, 1'b0, 0, 1'b1, 1'b1));
        send(mk(1'b1, 0, 0, 1'b1, 4, 1'b1, 1'b0));
        // flush coinciding with load-use
        send(mk(1'b1, 1, 0, 1'b0, 10, 1'b1, 1'b1));
        issue(mk(1'b1, 10, 2, 1'b1, 11, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, st);
        // freeze for three cycles with a load-use pending
        send(mk(1'b1, 1, 0, 1'b0, 12, 1'b1, 1'b1));
        cur = mk(1'b1, 12, 3, 1'b1, 13, 1'b1, 1'b0);
        repeat (3) issue(cur, 1'b0, 1'b1, 1'b0, st);
        send(cur);
        // counter saturation over five load-use pairs
        for (int k = 0; k < 5; k++) begin
            send(mk(1'b1, 2, 0, 1'b0, 14, 1'b1, 1'b1));
            send(mk(1'b1, 3, 14, 1'b1, 15, 1'b1, 1'b0));
        end
        // reset during a load-use stall, then an idle cycle
        send(mk(1'b1, 1, 0, 1'b0, 11, 1'b1, 1'b1));
        issue(mk(1'b1, 11, 0, 1'b0, 5, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, st);
        send(empty_instr());

        // Randomized traffic; ID holds its instruction across stalls and freezes
        cur = rnd_instr();
        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 99) < 8);
            bz = ($urandom_range(0, 99) < 10);
            rr = ($urandom_range(0, 99) < 2);
            issue(cur, fl, bz, rr, st);
            if (rr || (fl && !bz) || !(st || bz)) cur = rnd_instr();
        end

        wait_n = 0;
        while ((sbq.size() > 0) && (wait_n < 10)) begin
            @(negedge clk);
            wait_n++;
        end
        chk("scoreboard_drain", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
